// File: rtl/a23_cache_flush_ctrl.sv
// a23_cache_flush_ctrl: sequences a full tag-RAM invalidate for the Amber 23 cache,
// stalling the core until every line of every way has been written invalid.
// Optional build macro A23_FLUSH_COUNT_EN enables the saturating completed-flush counter;
// without it o_flush_count is tied to zero and no counter flops exist.
module a23_cache_flush_ctrl #(
    parameter int LINES   = 256,
    parameter int LINE_AW = 8,
    parameter int WAYS    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush_req,
    input  logic               i_disruptive_hit,
    input  logic               i_cache_busy,
    output logic               o_stall,
    output logic               o_busy,
    output logic [WAYS-1:0]    o_tag_wenable,
    output logic [LINE_AW-1:0] o_tag_addr,
    output logic               o_tag_valid,
    output logic               o_flush_done,
    output logic [15:0]        o_flush_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_WALK = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [LINE_AW-1:0] LAST = LINE_AW'(LINES - 1);

    logic [1:0]         state, state_nxt;
    logic [LINE_AW-1:0] line, line_nxt;
    logic               pending, pending_nxt;
    logic               req;

    assign req = i_flush_req | i_disruptive_hit;

    // Next-state decode; the line counter only moves while walking and wraps to 0 on the last line.
    always_comb begin
        state_nxt   = state;
        line_nxt    = line;
        pending_nxt = pending;
        case (state)
            S_IDLE: state_nxt = req ? (i_cache_busy ? S_WAIT : S_WALK) : S_IDLE;
            S_WAIT: begin
                pending_nxt = pending | req;
                state_nxt   = i_cache_busy ? S_WAIT : S_WALK;
            end
            S_WALK: begin
                pending_nxt = pending | req;
                line_nxt    = line + 1'b1;
                state_nxt   = (line == LAST) ? S_DONE : S_WALK;
            end
            default: begin
                pending_nxt = 1'b0;
                state_nxt   = (pending | req) ? (i_cache_busy ? S_WAIT : S_WALK) : S_IDLE;
            end
        endcase
    end

    // Controller state; asynchronous reset aborts a walk with no further tag writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            line    <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            line    <= line_nxt;
            pending <= pending_nxt;
        end
    end

    assign o_busy        = state != S_IDLE;
    assign o_stall       = req | o_busy;
    assign o_tag_wenable = (state == S_WALK) ? {WAYS{1'b1}} : '0;
    assign o_tag_addr    = line;
    assign o_tag_valid   = 1'b0;
    assign o_flush_done  = state == S_DONE;

`ifdef A23_FLUSH_COUNT_EN
    logic [15:0] flush_count;

    // Count completed walks, holding at all ones rather than wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            flush_count <= '0;
        else if (o_flush_done && flush_count != 16'hFFFF)
            flush_count <= flush_count + 16'd1;
    end

    assign o_flush_count = flush_count;
`else
    assign o_flush_count = 16'd0;
`endif
endmodule
